// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-at-a-time imem req/ack, valid/ready to decode.
// Redirects squash wrong-path fetches; an outstanding request is always drained.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH_P  = 32,
  parameter int unsigned DATA_WIDTH_P  = 32,
  parameter int unsigned OP_WIDTH_P    = 6,
  parameter int unsigned FUNCT_WIDTH_P = 6,
  parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_imem_req,
  output logic [ADDR_WIDTH_P-1:0]  o_imem_addr,
  input  logic                     i_imem_ack,
  input  logic [DATA_WIDTH_P-1:0]  i_imem_rdata,
  output logic                     o_instr_valid,
  input  logic                     i_instr_ready,
  output logic [DATA_WIDTH_P-1:0]  o_instr,
  output logic [OP_WIDTH_P-1:0]    o_opcode,
  output logic [FUNCT_WIDTH_P-1:0] o_function,
  output logic [ADDR_WIDTH_P-1:0]  o_pc_plus4,
  input  logic                     i_redirect,
  input  logic [ADDR_WIDTH_P-1:0]  i_redirect_pc
);

  typedef enum logic [1:0] {
    IDLE, REQ, HOLD, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH_P-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH_P-1:0] tgt_q, tgt_d;
  logic [ADDR_WIDTH_P-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH_P-1:0] pc4_q, pc4_d;
  logic [DATA_WIDTH_P-1:0] instr_q, instr_d;
  logic                    req_q, req_d;
  logic                    valid_q, valid_d;

  logic [ADDR_WIDTH_P-1:0] redir_pc;
  logic [ADDR_WIDTH_P-1:0] pc_inc;
  logic                    ack;
  logic                    xfer;
  logic                    redir_lsb_unused;

  assign redir_pc = {i_redirect_pc[ADDR_WIDTH_P-1:2], 2'b00};
  assign redir_lsb_unused = ^i_redirect_pc[1:0];
  assign pc_inc = pc_q + ADDR_WIDTH_P'(4);
  // ack only counts while a request is actually on the bus
  assign ack  = req_q & i_imem_ack;
  assign xfer = valid_q & i_instr_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_P;
      tgt_q   <= RESET_PC_P;
      addr_q  <= RESET_PC_P;
      pc4_q   <= '0;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (i_redirect) begin
          state_d = (req_q && !i_imem_ack) ? DRAIN : REQ;
        end else if (ack) begin
          state_d = HOLD;
        end
      end
      HOLD:  if (i_redirect || xfer) state_d = REQ;
      DRAIN: if (ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: if (i_redirect) pc_d = redir_pc;
      REQ: begin
        if (i_redirect) begin
          if (req_q && !i_imem_ack) tgt_d = redir_pc;
          else                      pc_d  = redir_pc;
        end else if (ack) begin
          instr_d = i_imem_rdata;
          pc4_d   = pc_inc;
          pc_d    = pc_inc;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          valid_d = 1'b0;
          pc_d    = redir_pc;
        end else if (xfer) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (i_redirect) tgt_d = redir_pc;
        if (ack)        pc_d  = tgt_d;
      end
      default: ;
    endcase
    // redirect colliding with ack leaves a one-cycle gap before reissue
    req_d  = ((state_d == REQ) || (state_d == DRAIN)) &&
             !((state_q == REQ) && i_redirect && ack);
    addr_d = pc_d;
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = addr_q;
  assign o_instr_valid = valid_q;
  assign o_instr       = instr_q;
  assign o_pc_plus4    = pc4_q;
  assign o_opcode      = instr_q[DATA_WIDTH_P-1 -: OP_WIDTH_P];
  assign o_function    = instr_q[FUNCT_WIDTH_P-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vector table for fetch_unit plus hand sequences
// for drain retargeting and a bounded fetch wait.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  int nchk  = 0;
  int nfail = 0;

  fetch_unit dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr       (instr),
    .o_opcode      (opcode),
    .o_function    (funct),
    .o_pc_plus4    (pc_plus4),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rs, logic ak, logic [31:0] rd, logic ry,
    logic rr, logic [31:0] rp, logic rq, logic [31:0] ad,
    logic vl, logic [31:0] in, logic [31:0] p4);
    vec_t v;
    v.rst = rs; v.ack = ak; v.rdata = rd; v.rdy = ry;
    v.redir = rr; v.rpc = rp; v.req = rq; v.addr = ad;
    v.valid = vl; v.instr = in; v.pc4 = p4;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(logic rs, logic ak, logic [31:0] rd,
                       logic ry, logic rr, logic [31:0] rp);
    rst = rs; imem_ack = ak; imem_rdata = rd;
    instr_ready = ry; redirect = rr; redirect_pc = rp;
  endtask

  initial begin
    logic [31:0] e_instr;
    bit          got_valid;

    // cols: rst ack rdata rdy redir rpc | req addr valid instr pc4
    // c0 IDLE: stray ack ignored
    vecs.push_back(mk(0,1,32'hDEADBEEF,0,0,0, 0,32'h0,0,32'h0,32'h0));
    // c1 REQ: ack in first cycle
    vecs.push_back(mk(0,1,32'h8C220004,0,0,0, 1,32'h0,0,32'h0,32'h0));
    // c2..c6 HOLD with ready low
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,32'h0,0,0,0, 0,32'h4,1,32'h8C220004,32'h4));
    // c7 transfer
    vecs.push_back(mk(0,0,32'h0,1,0,0, 0,32'h4,1,32'h8C220004,32'h4));
    // c8..c10 REQ, ack late
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,32'h0,1,0,0, 1,32'h4,0,32'h8C220004,32'h4));
    // c11 ack
    vecs.push_back(mk(0,1,32'h00430820,1,0,0, 1,32'h4,0,32'h8C220004,32'h4));
    // c12 HOLD, immediate transfer
    vecs.push_back(mk(0,0,32'h0,1,0,0, 0,32'h8,1,32'h00430820,32'h8));
    // c13 REQ
    vecs.push_back(mk(0,0,32'h0,1,0,0, 1,32'h8,0,32'h00430820,32'h8));
    // c14 REQ redirect 0x40 without ack -> DRAIN
    vecs.push_back(mk(0,0,32'h0,1,1,32'h40, 1,32'h8,0,32'h00430820,32'h8));
    // c15 DRAIN: late ack, data dropped
    vecs.push_back(mk(0,1,32'hBAD0BAD0,1,0,0, 1,32'h8,0,32'h00430820,32'h8));
    // c16 REQ at target
    vecs.push_back(mk(0,1,32'h20010005,0,0,0, 1,32'h40,0,32'h00430820,32'h8));
    // c17 HOLD: redirect 0x103
    vecs.push_back(mk(0,0,32'h0,0,1,32'h103, 0,32'h44,1,32'h20010005,32'h44));
    // c18 REQ 0x100: ack + redirect together
    vecs.push_back(mk(0,1,32'h8C220008,0,1,32'hFFFFFFFC,
                      1,32'h100,0,32'h20010005,32'h44));
    // c19 req gap, stray ack ignored
    vecs.push_back(mk(0,1,32'h11111111,0,0,0,
                      0,32'hFFFFFFFC,0,32'h20010005,32'h44));
    // c20 REQ at top of memory
    vecs.push_back(mk(0,1,32'h0000000D,0,0,0,
                      1,32'hFFFFFFFC,0,32'h20010005,32'h44));
    // c21 HOLD: pc wrapped
    vecs.push_back(mk(0,0,32'h0,1,0,0, 0,32'h0,1,32'h0000000D,32'h0));
    // c22 REQ: reset with in-flight ack
    vecs.push_back(mk(1,1,32'h22222222,0,0,0, 1,32'h0,0,32'h0000000D,32'h0));
    // c23 IDLE after reset
    vecs.push_back(mk(0,0,32'h0,0,0,0, 0,32'h0,0,32'h0,32'h0));

    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata,
            vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      e_instr = vecs[i].instr;
      chk($sformatf("c%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk($sformatf("c%0d addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("c%0d valid", i), {31'b0, instr_valid},
          {31'b0, vecs[i].valid});
      chk($sformatf("c%0d instr", i), instr, e_instr);
      chk($sformatf("c%0d opcode", i), {26'b0, opcode}, {26'b0, e_instr[31:26]});
      chk($sformatf("c%0d funct", i), {26'b0, funct}, {26'b0, e_instr[5:0]});
      chk($sformatf("c%0d pc4", i), pc_plus4, vecs[i].pc4);
      @(negedge clk);
    end

    // drain target overwritten by a second redirect
    drive(0, 0, 0, 0, 1, 32'h200);
    chk("d0 req", {31'b0, imem_req}, 32'h1);
    chk("d0 addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h300);
    chk("d1 req", {31'b0, imem_req}, 32'h1);
    chk("d1 addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 1, 32'h33333333, 0, 0, 0);
    chk("d2 addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("d3 req", {31'b0, imem_req}, 32'h1);
    chk("d3 addr", imem_addr, 32'h300);
    chk("d3 valid", {31'b0, instr_valid}, 32'h0);

    // bounded wait: memory answers, instruction must surface
    drive(0, 1, 32'h8FA40010, 1, 0, 0);
    got_valid = 0;
    for (int n = 0; n < 10 && !got_valid; n++) begin
      @(negedge clk);
      if (instr_valid) got_valid = 1;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("w valid", {31'b0, got_valid}, 32'h1);
    chk("w instr", instr, 32'h8FA40010);
    chk("w pc4", pc_plus4, 32'h304);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
